// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles big-endian 16-bit words from a ready/valid
// byte source, writes them to instruction memory and holds the CPU in reset until HALT.
module prog_loader #(
    parameter int NB_INSTRUCTION = 16,
    parameter int NB_ADDR        = 11,
    parameter int NB_OPCODE      = 5
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [7:0]                i_rx_data,
    input  logic                      i_rx_valid,
    output logic                      o_rx_ready,
    output logic                      o_mem_wr_enable,
    output logic [NB_ADDR-1:0]        o_mem_addr,
    output logic [NB_INSTRUCTION-1:0] o_mem_data,
    output logic                      o_cpu_reset,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_overflow,
    output logic [NB_ADDR:0]          o_word_count
);

    typedef enum logic [2:0] {
        IDLE, LOAD_HI, LOAD_LO, WRITE, DONE, ERROR
    } state_t;

    state_t                    state_q, state_d;
    logic [7:0]                hi_q, hi_d;
    logic [NB_ADDR-1:0]        addr_q, addr_d;
    logic [NB_INSTRUCTION-1:0] data_q, data_d;
    logic [NB_ADDR:0]          count_q, count_d;
    logic                      rx_ready_q, rx_ready_d;
    logic                      wr_en_q, wr_en_d;
    logic                      cpu_reset_q, cpu_reset_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      overflow_q, overflow_d;

    logic xfer;
    logic is_halt;
    logic addr_last;

    assign xfer      = rx_ready_q & i_rx_valid;
    assign is_halt   = (data_q[NB_INSTRUCTION-1 -: NB_OPCODE] == '0);
    assign addr_last = &addr_q;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        hi_d     = hi_q;
        addr_d   = addr_q;
        data_d   = data_q;
        count_d  = count_q;

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (i_start) begin
                    state_d = LOAD_HI;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            LOAD_HI: begin
                if (xfer) begin
                    hi_d    = i_rx_data;
                    state_d = LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (xfer) begin
                    data_d  = NB_INSTRUCTION'({hi_q, i_rx_data});
                    state_d = WRITE;
                end
            end
            WRITE: begin
                count_d = count_q + (NB_ADDR+1)'(1);
                if (is_halt) begin
                    state_d = DONE;
                end else if (addr_last) begin
                    // Memory is full and no HALT seen: stop rather than wrap onto word 0.
                    state_d = ERROR;
                end else begin
                    addr_d  = addr_q + NB_ADDR'(1);
                    state_d = LOAD_HI;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered copies of what the next state implies.
        rx_ready_d  = (state_d == LOAD_HI) || (state_d == LOAD_LO);
        wr_en_d     = (state_d == WRITE);
        busy_d      = (state_d == LOAD_HI) || (state_d == LOAD_LO) || (state_d == WRITE);
        done_d      = (state_d == DONE);
        overflow_d  = (state_d == ERROR);
        cpu_reset_d = (state_d != DONE);
    end

    always_ff @(posedge i_clock) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (i_reset) begin
            state_q     <= IDLE;
            hi_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            count_q     <= '0;
            rx_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            count_q     <= count_d;
            rx_ready_q  <= rx_ready_d;
            wr_en_q     <= wr_en_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign o_rx_ready      = rx_ready_q;
    assign o_mem_wr_enable = wr_en_q;
    assign o_mem_addr      = addr_q;
    assign o_mem_data      = data_q;
    assign o_cpu_reset     = cpu_reset_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_overflow      = overflow_q;
    assign o_word_count    = count_q;

endmodule
